load_store_unit: RTL and testbench

//  Sits between the datapath and data_memory. Accepts byte/half/word load and store requests on a

---
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit in front of a word-indexed data memory
// Sub-word stores are read-modify-write; misaligned requests answer with an error and no access.
module load_store_unit #(
  parameter int N = 32,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [M-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic         MemW,
  output logic         MemR,
  output logic [M-1:0] address,
  output logic [N-1:0] Wdata,
  input  logic [N-1:0] Rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t       state;
  logic [M-1:0] addr_q;
  logic [1:0]   size_q;
  logic         we_q;
  logic         unsigned_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] merge_q;

  logic         misaligned;
  logic [7:0]   lane_byte;
  logic [15:0]  lane_half;
  logic [N-1:0] load_ext;
  logic [3:0]   byte_en;
  logic [N-1:0] wdata_rep;
  logic [N-1:0] merged;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    lane_byte = Rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? Rdata[31:16] : Rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{(N-8){~unsigned_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{(N-16){~unsigned_q & lane_half[15]}}, lane_half};
      default: load_ext = Rdata;
    endcase
  end

  // Replicate store data across lanes so the byte enables alone select where it lands.
  always_comb begin
    if (size_q == 2'b00) begin
      byte_en   = 4'b0001 << addr_q[1:0];
      wdata_rep = {4{wdata_q[7:0]}};
    end else begin
      byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata_q[15:0]}};
    end
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = byte_en[i] ? wdata_rep[8*i +: 8] : Rdata[8*i +: 8];
    end
  end

  // Memory strobes come straight from the state register so reset removes them asynchronously.
  assign MemR    = (state == READ);
  assign MemW    = (state == WRITE);
  assign address = (MemR || MemW) ? (addr_q >> 2) : '0;
  assign Wdata   = MemW ? ((size_q == 2'b10) ? wdata_q : merge_q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      merge_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            we_q       <= req_we;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            if (misaligned) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              resp_err <= 1'b0;
              state    <= (req_we && req_size == 2'b10) ? WRITE : READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            merge_q <= merged;
            state   <= WRITE;
          end else begin
            resp_rdata <= load_ext;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WRITE: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
// A small word-indexed memory model sits on the memory port.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemW;
  logic        MemR;
  logic [31:0] address;
  logic [31:0] Wdata;
  logic [31:0] Rdata;

  logic [31:0] mem [0:63];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign Rdata = mem[address[5:0]];
  always @(posedge clk) if (MemW) mem[address[5:0]] <= Wdata;

  load_store_unit #(.N(32), .M(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemW(MemW), .MemR(MemR), .address(address), .Wdata(Wdata), .Rdata(Rdata)
  );

  // Presents one request for exactly one accept edge; returns #1 after that edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge (1 = visible right after it) until resp_valid.
  task automatic wait_resp(output int cycles);
    cycles = 1;
    while (!resp_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic retire;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if ({req_ready, resp_valid, MemW, MemR, resp_err} !== 5'b10000 ||
        address !== 32'h0 || Wdata !== 32'h0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b memw=%b memr=%b err=%b addr=%h wdata=%h rdata=%h, need 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, MemW, MemR, resp_err, address, Wdata, resp_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_word(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input string name);
    int cyc;
    issue(we, 2'b10, 1'b0, addr, wdata);
    checks++;
    if (MemW !== we || MemR !== !we || address !== (addr >> 2) || Wdata !== (we ? wdata : 32'h0)) begin
      errors++;
      $display("FAIL %s access: memw=%b memr=%b addr=%h wdata=%h", name, MemW, MemR, address, Wdata);
    end
    wait_resp(cyc);
    checks++;
    if (cyc !== 2 || resp_err !== 1'b0 || resp_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s resp: latency=%0d err=%b rdata=%h, need 2 0 %h", name, cyc, resp_err, resp_rdata, exp_rdata);
    end
    retire();
  endtask

  task automatic test_sub_store(input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_word, input string name);
    int cyc;
    issue(1'b1, size, 1'b0, addr, wdata);
    checks++;
    if (MemR !== 1'b1 || MemW !== 1'b0 || address !== (addr >> 2)) begin
      errors++;
      $display("FAIL %s read phase: memr=%b memw=%b addr=%h", name, MemR, MemW, address);
    end
    @(posedge clk); #1;
    checks++;
    if (MemW !== 1'b1 || MemR !== 1'b0 || Wdata !== exp_word) begin
      errors++;
      $display("FAIL %s write phase: memw=%b memr=%b wdata=%h, need %h", name, MemW, MemR, Wdata, exp_word);
    end
    cyc = 2;
    while (!resp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 3 || resp_err !== 1'b0 || resp_rdata !== 32'h0 || mem[addr[7:2]] !== exp_word) begin
      errors++;
      $display("FAIL %s resp: latency=%0d err=%b rdata=%h mem=%h, need 3 0 0 %h",
               name, cyc, resp_err, resp_rdata, mem[addr[7:2]], exp_word);
    end
    retire();
  endtask

  task automatic test_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                           input logic [31:0] exp, input string name);
    int cyc;
    issue(1'b0, size, uns, addr, 32'h0);
    wait_resp(cyc);
    checks++;
    if (cyc !== 2 || resp_err !== 1'b0 || resp_rdata !== exp) begin
      errors++;
      $display("FAIL %s: latency=%0d err=%b rdata=%h, need 2 0 %h", name, cyc, resp_err, resp_rdata, exp);
    end
    retire();
  endtask

  task automatic test_misaligned(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                 input string name);
    logic touched;
    issue(we, size, 1'b0, addr, 32'h5555_5555);
    touched = MemR | MemW;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || touched !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%b err=%b rdata=%h mem_access=%b, need 1 1 0 0",
               name, resp_valid, resp_err, resp_rdata, touched);
    end
    retire();
    checks++;
    if (req_ready !== 1'b1 || MemR !== 1'b0 || MemW !== 1'b0) begin
      errors++;
      $display("FAIL %s exit: ready=%b memr=%b memw=%b, need 1 0 0", name, req_ready, MemR, MemW);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    resp_ready = 1'b0;
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    wait_resp(cyc);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_BEEF || resp_err !== 1'b0 ||
          req_ready !== 1'b0 || MemR !== 1'b0 || MemW !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: valid=%b rdata=%h err=%b ready=%b memr=%b memw=%b, need 1 0000beef 0 0 0 0",
                 i, resp_valid, resp_rdata, resp_err, req_ready, MemR, MemW);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    retire();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure release: ready=%b valid=%b, need 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_in_write;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1111_1111);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (MemW !== 1'b0 || address !== 32'h0 || Wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_write: memw=%b addr=%h wdata=%h, need 0 0 0", MemW, address, Wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (mem[4] !== 32'hDEAD_BEEF || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_write after: mem=%h ready=%b valid=%b, need deadbeef 1 0", mem[4], req_ready, resp_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;

    test_reset();
    test_word(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, "sw_0x10");
    test_word(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, "lw_0x10");
    test_sub_store(2'b00, 32'h11, 32'h0000_00AA, 32'hDEAD_AAEF, "sb_0x11");
    test_word(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, "sw_restore");
    test_load(2'b00, 1'b0, 32'h13, 32'hFFFF_FFDE, "lb_0x13");
    test_load(2'b00, 1'b1, 32'h13, 32'h0000_00DE, "lbu_0x13");
    test_load(2'b01, 1'b0, 32'h12, 32'hFFFF_DEAD, "lh_0x12");
    test_load(2'b01, 1'b1, 32'h12, 32'h0000_DEAD, "lhu_0x12");
    test_load(2'b00, 1'b0, 32'h11, 32'hFFFF_FFBE, "lb_0x11");
    test_load(2'b01, 1'b0, 32'h10, 32'hFFFF_BEEF, "lh_0x10");
    test_misaligned(1'b0, 2'b10, 32'h12, "lw_0x12_err");
    test_misaligned(1'b1, 2'b01, 32'h11, "sh_0x11_err");
    test_misaligned(1'b0, 2'b11, 32'h10, "size3_err");
    test_sub_store(2'b01, 32'h22, 32'hFFFF_1234, 32'h1234_0000, "sh_0x22");
    test_load(2'b00, 1'b0, 32'h23, 32'h0000_0012, "lb_0x23");
    test_backpressure();
    test_reset_in_write();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, need completion");
    $fatal(1);
  end

endmodule
